gba_bus_arbiter: RTL and testbench
==================================

# gba_bus_arbiter

Arbitrates the single shared system memory bus (mem_top port) between the CPU and the DMA engine. Ownership is held in a registered state machine and changes only at access boundaries (cycles where the memory returns `bus_pause`=0). DMA has priority; an optional run limit forces a one-access CPU slot during long DMA transfers. Sits between `cpu_top`/`dma_top` and `mem_top` in `gba_top`, replacing their direct shared drive of `bus_addr`/`bus_wdata`/`bus_size`/`bus_write`.

## Interface
- MAX_DMA_RUN, 0, consecutive completed DMA accesses before one CPU slot is forced; 0 = unlimited
- clk  in  1  system clock (gba_clk)
- rst_b  in  1  asynchronous, active-low reset
- cpu_addr / cpu_wdata  in  32  CPU access address / write data
- cpu_size  in  2  CPU access size (0 byte, 1 half, 2 word)
- cpu_write  in  1  CPU write strobe
- cpu_rdata  out  32  read data to CPU
- cpu_pause  out  1  CPU stall
- cpu_dma_active  out  1  DMA owns bus (to cpu `dmaActive`)
- dma_req  in  1  DMA wants the bus; held high for the whole transfer
- dma_addr / dma_wdata  in  32  DMA address / write data
- dma_size  in  2  DMA access size
- dma_write  in  1  DMA write strobe
- dma_grant  out  1  DMA owns bus this cycle
- dma_rdata  out  32  read data to DMA
- dma_pause  out  1  DMA stall
- bus_addr / bus_wdata  out  32  to mem_top
- bus_size  out  2  to mem_top
- bus_write  out  1  to mem_top
- bus_rdata  in  32  from mem_top
- bus_pause  in  1  memory busy; access completes on a cycle with bus_pause=0

## Operation
- States: OWN_CPU, OWN_DMA, OWN_CPU_SLOT. Reset state OWN_CPU, run counter 0.
- "Done" = `bus_pause`=0 this cycle. All transitions are taken only on done cycles.
- OWN_CPU: bus driven from cpu_*; `cpu_pause`=`bus_pause`. If `dma_req` && done, go to OWN_DMA and clear the run counter.
- OWN_DMA: bus driven from dma_*; `dma_grant`=1, `cpu_dma_active`=1, `cpu_pause`=1, `dma_pause`=`bus_pause`.
  - If `dma_req`=0, `bus_write` is forced 0. On done, go to OWN_CPU.
  - On done with `dma_req`=1, increment the counter. If MAX_DMA_RUN≠0 and the counter reaches MAX_DMA_RUN, go to OWN_CPU_SLOT.
- OWN_CPU_SLOT: driven like OWN_CPU, and `dma_pause`=1. On done, go to OWN_DMA if `dma_req`, else OWN_CPU. The counter is cleared either way.
- In non-owner states: `dma_pause`=1; `dma_grant`=0 and `cpu_dma_active`=0 outside OWN_DMA.
- `cpu_rdata` and `dma_rdata` both equal `bus_rdata` at all times. Consumers qualify reads by their own pause signal.
- Run counter width is $clog2(MAX_DMA_RUN+1), minimum 1. It saturates and cannot wrap, because the transition occurs at MAX_DMA_RUN.
- Simultaneous events:
  - `dma_req` rising on the same done cycle as a CPU access: the CPU access completes (`cpu_pause`=0) and DMA owns the bus next cycle.
  - `dma_req` falling while the bus is paused: ownership holds until done, with writes suppressed.

## Timing
- Outputs are combinational from the state flop and the inputs. No registered data path and no added memory latency.
- `dma_req` rise → `dma_grant`: 1 cycle if the bus is idle; otherwise 1 cycle after the first done cycle.
- `dma_req` fall → CPU resumes ownership: 1 cycle after the next done cycle.
- Reset value of every output while `rst_b`=0 (state OWN_CPU):
  - `bus_*` mirror cpu_*; `cpu_rdata` and `dma_rdata` mirror `bus_rdata`.
  - `cpu_pause`=`bus_pause`, `dma_grant`=0, `dma_pause`=1, `cpu_dma_active`=0.
- Reset asserted mid-transfer forces OWN_CPU immediately (asynchronously). The aborted DMA access is not completed.

## Structure
- Shared package `gba_bus_pkg`:
  - `bus_owner_t` enum {OWN_CPU, OWN_DMA, OWN_CPU_SLOT}.
  - Size constants SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2.
- One sub-module, `gba_bus_mux`: purely combinational owner-select of addr/wdata/size/write, including the write suppression.
- FSM and run counter live in `gba_bus_arbiter`.

## Test plan
- Reset with `bus_pause`=0 and `dma_req`=1 → `dma_grant` stays 0 until `rst_b` rises, then is 1 exactly one cycle later; `bus_addr` switches to `dma_addr`.
- CPU read with `bus_pause` high for 3 cycles; `dma_req` rises on the 2nd → `dma_grant` rises the cycle after `bus_pause` falls; `cpu_pause`=0 on that done cycle, then 1.
- MAX_DMA_RUN=4, `dma_req` held, `bus_pause`=0 → 4 cycles with `dma_grant`=1, 1 cycle with `cpu_pause`=0 and `dma_pause`=1, then DMA again. Pattern repeats.
- MAX_DMA_RUN=0, 1000-access DMA run → no CPU slot; `cpu_pause`=1 throughout.
- `dma_req` drops while `bus_pause`=1 with `dma_write`=1 → `bus_write`=0 immediately; ownership returns to CPU one cycle after `bus_pause` falls.
- `rst_b` low mid-DMA → state OWN_CPU, `dma_grant`=0 and `cpu_dma_active`=0 in the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/gba_bus_pkg.sv
// Shared types for the GBA system bus arbiter.
// Owner states and access-size encodings.
package gba_bus_pkg;

    typedef enum logic [1:0] {
        OWN_CPU      = 2'd0,
        OWN_DMA      = 2'd1,
        OWN_CPU_SLOT = 2'd2
    } bus_owner_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/gba_bus_arbiter_if.sv
// CPU, DMA and memory-side bus bundle for the arbiter.
// slave: arbiter view; master: the surrounding system.
interface gba_bus_arbiter_if;

    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [1:0]  cpu_size;
    logic        cpu_write;
    logic [31:0] cpu_rdata;
    logic        cpu_pause;
    logic        cpu_dma_active;

    logic        dma_req;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [1:0]  dma_size;
    logic        dma_write;
    logic        dma_grant;
    logic [31:0] dma_rdata;
    logic        dma_pause;

    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [1:0]  bus_size;
    logic        bus_write;
    logic [31:0] bus_rdata;
    logic        bus_pause;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_size, cpu_write,
        output cpu_rdata, cpu_pause, cpu_dma_active,
        input  dma_req, dma_addr, dma_wdata, dma_size,
        input  dma_write,
        output dma_grant, dma_rdata, dma_pause,
        output bus_addr, bus_wdata, bus_size, bus_write,
        input  bus_rdata, bus_pause
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_size, cpu_write,
        input  cpu_rdata, cpu_pause, cpu_dma_active,
        output dma_req, dma_addr, dma_wdata, dma_size,
        output dma_write,
        input  dma_grant, dma_rdata, dma_pause,
        input  bus_addr, bus_wdata, bus_size, bus_write,
        output bus_rdata, bus_pause
    );

endinterface

// File: rtl/gba_bus_mux.sv
// Owner select of the memory bus request fields.
// In: owner, dma_req, cpu_*/dma_* request; out: bus_* request.
module gba_bus_mux
    import gba_bus_pkg::*;
(
    input  bus_owner_t  owner,
    input  logic        dma_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_write,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [1:0]  dma_size,
    input  logic        dma_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [1:0]  bus_size,
    output logic        bus_write
);

    always_comb begin
        bus_addr  = cpu_addr;
        bus_wdata = cpu_wdata;
        bus_size  = cpu_size;
        bus_write = cpu_write;
        if (owner == OWN_DMA) begin
            bus_addr  = dma_addr;
            bus_wdata = dma_wdata;
            bus_size  = dma_size;
            // A withdrawn DMA keeps the bus until done but
            // must not commit a write.
            bus_write = dma_write & dma_req;
        end
    end

endmodule

// File: rtl/gba_bus_arbiter.sv
// CPU/DMA arbiter for the shared memory bus, DMA priority.
// Ports: clk, rst_b (async low), bus (slave view of bundle).
module gba_bus_arbiter
    import gba_bus_pkg::*;
#(
    parameter int unsigned MAX_DMA_RUN = 0
) (
    input  logic              clk,
    input  logic              rst_b,
    gba_bus_arbiter_if.slave  bus
);

    localparam int unsigned CLOG = $clog2(MAX_DMA_RUN + 1);
    localparam int unsigned CW   = (CLOG < 1) ? 1 : CLOG;
    localparam logic [CW-1:0] CNT_TOP = '1;
    localparam logic [CW:0]   RUN_LIM = (CW+1)'(MAX_DMA_RUN);

    bus_owner_t    state;
    logic [CW-1:0] run_cnt;
    logic [CW:0]   run_nxt;
    logic          done;
    logic          hit_limit;
    logic          is_dma;

    assign done      = ~bus.bus_pause;
    assign run_nxt   = {1'b0, run_cnt} + (CW+1)'(1);
    assign hit_limit = (MAX_DMA_RUN != 0) &&
                       (run_nxt == RUN_LIM);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state   <= OWN_CPU;
            run_cnt <= '0;
        end else if (done) begin
            unique case (state)
                OWN_CPU: begin
                    if (bus.dma_req) begin
                        state   <= OWN_DMA;
                        run_cnt <= '0;
                    end
                end
                OWN_DMA: begin
                    if (!bus.dma_req) begin
                        state <= OWN_CPU;
                    end else begin
                        // Saturate so unlimited runs never wrap.
                        if (run_cnt != CNT_TOP)
                            run_cnt <= run_nxt[CW-1:0];
                        if (hit_limit)
                            state <= OWN_CPU_SLOT;
                    end
                end
                OWN_CPU_SLOT: begin
                    run_cnt <= '0;
                    state   <= bus.dma_req ? OWN_DMA : OWN_CPU;
                end
                default: begin
                    state   <= OWN_CPU;
                    run_cnt <= '0;
                end
            endcase
        end
    end

    assign is_dma = (state == OWN_DMA);

    assign bus.dma_grant      = is_dma;
    assign bus.cpu_dma_active = is_dma;
    assign bus.cpu_pause      = is_dma | bus.bus_pause;
    assign bus.dma_pause      = ~is_dma | bus.bus_pause;
    assign bus.cpu_rdata      = bus.bus_rdata;
    assign bus.dma_rdata      = bus.bus_rdata;

    gba_bus_mux u_mux (
        .owner     (state),
        .dma_req   (bus.dma_req),
        .cpu_addr  (bus.cpu_addr),
        .cpu_wdata (bus.cpu_wdata),
        .cpu_size  (bus.cpu_size),
        .cpu_write (bus.cpu_write),
        .dma_addr  (bus.dma_addr),
        .dma_wdata (bus.dma_wdata),
        .dma_size  (bus.dma_size),
        .dma_write (bus.dma_write),
        .bus_addr  (bus.bus_addr),
        .bus_wdata (bus.bus_wdata),
        .bus_size  (bus.bus_size),
        .bus_write (bus.bus_write)
    );

endmodule

// File: tb/tb_gba_bus_arbiter.sv
// Directed bench for gba_bus_arbiter.
// Two instances: run limit 4 and unlimited.
module tb_gba_bus_arbiter;
    import gba_bus_pkg::*;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    gba_bus_arbiter_if b4();
    gba_bus_arbiter_if b0();

    gba_bus_arbiter #(.MAX_DMA_RUN(4)) dut4 (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (b4)
    );

    gba_bus_arbiter #(.MAX_DMA_RUN(0)) dut0 (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (b0)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs;
        b4.cpu_addr  = 32'h0;
        b4.cpu_wdata = 32'h0;
        b4.cpu_size  = SIZE_WORD;
        b4.cpu_write = 1'b0;
        b4.dma_req   = 1'b0;
        b4.dma_addr  = 32'h0;
        b4.dma_wdata = 32'h0;
        b4.dma_size  = SIZE_WORD;
        b4.dma_write = 1'b0;
        b4.bus_rdata = 32'h0;
        b4.bus_pause = 1'b0;
        b0.cpu_addr  = 32'h0;
        b0.cpu_wdata = 32'h0;
        b0.cpu_size  = SIZE_BYTE;
        b0.cpu_write = 1'b0;
        b0.dma_req   = 1'b0;
        b0.dma_addr  = 32'h0;
        b0.dma_wdata = 32'h0;
        b0.dma_size  = SIZE_BYTE;
        b0.dma_write = 1'b0;
        b0.bus_rdata = 32'h0;
        b0.bus_pause = 1'b0;
    endtask

    task automatic test_reset;
        rst_b        = 1'b0;
        b4.dma_req   = 1'b1;
        b4.bus_pause = 1'b1;
        b4.cpu_addr  = 32'h0000_1000;
        b4.dma_addr  = 32'h0200_0000;
        b4.bus_rdata = 32'hCAFE_F00D;
        repeat (3) @(negedge clk);
        checks++;
        if (b4.cpu_pause !== 1'b1) begin
            errors++;
            $display("FAIL rst_cpu_pause_hi: got %b want 1",
                     b4.cpu_pause);
        end
        b4.bus_pause = 1'b0;
        #1;
        checks++;
        if (b4.cpu_pause !== 1'b0) begin
            errors++;
            $display("FAIL rst_cpu_pause_lo: got %b want 0",
                     b4.cpu_pause);
        end
        checks++;
        if (b4.dma_grant !== 1'b0) begin
            errors++;
            $display("FAIL rst_grant: got %b want 0",
                     b4.dma_grant);
        end
        checks++;
        if (b4.cpu_dma_active !== 1'b0) begin
            errors++;
            $display("FAIL rst_active: got %b want 0",
                     b4.cpu_dma_active);
        end
        checks++;
        if (b4.dma_pause !== 1'b1) begin
            errors++;
            $display("FAIL rst_dma_pause: got %b want 1",
                     b4.dma_pause);
        end
        checks++;
        if (b4.bus_addr !== 32'h0000_1000) begin
            errors++;
            $display("FAIL rst_bus_addr: got %h want %h",
                     b4.bus_addr, 32'h0000_1000);
        end
        checks++;
        if (b4.cpu_rdata !== 32'hCAFE_F00D ||
            b4.dma_rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL rst_rdata: got %h/%h want %h",
                     b4.cpu_rdata, b4.dma_rdata, 32'hCAFE_F00D);
        end
        rst_b = 1'b1;
        #1;
        checks++;
        if (b4.dma_grant !== 1'b0) begin
            errors++;
            $display("FAIL rel_grant_early: got %b want 0",
                     b4.dma_grant);
        end
        step();
        checks++;
        if (b4.dma_grant !== 1'b1) begin
            errors++;
            $display("FAIL rel_grant: got %b want 1",
                     b4.dma_grant);
        end
        checks++;
        if (b4.bus_addr !== 32'h0200_0000) begin
            errors++;
            $display("FAIL rel_bus_addr: got %h want %h",
                     b4.bus_addr, 32'h0200_0000);
        end
    endtask

    task automatic test_cpu_read;
        // DMA withdraws on a done cycle; CPU owns next.
        b4.dma_req = 1'b0;
        step();
        b4.bus_pause = 1'b1;
        b4.cpu_addr  = 32'h0800_0010;
        for (int i = 1; i <= 5; i++) begin
            if (i == 2) b4.dma_req = 1'b1;
            if (i == 4) b4.bus_pause = 1'b0;
            @(negedge clk);
            checks++;
            if (b4.dma_grant !== (i == 5)) begin
                errors++;
                $display("FAIL rd_grant c%0d: got %b want %b",
                         i, b4.dma_grant, (i == 5));
            end
            checks++;
            if (b4.cpu_pause !== (i != 4)) begin
                errors++;
                $display("FAIL rd_cpu_pause c%0d: got %b want %b",
                         i, b4.cpu_pause, (i != 4));
            end
            if (i == 1) begin
                checks++;
                if (b4.bus_addr !== 32'h0800_0010) begin
                    errors++;
                    $display("FAIL rd_addr: got %h want %h",
                             b4.bus_addr, 32'h0800_0010);
                end
            end
            step();
        end
    endtask

    task automatic test_run_limit;
        b4.dma_req = 1'b0;
        step();
        b4.dma_req = 1'b1;
        @(negedge clk);
        checks++;
        if (b4.dma_grant !== 1'b0) begin
            errors++;
            $display("FAIL rl_pre_grant: got %b want 0",
                     b4.dma_grant);
        end
        step();
        for (int i = 0; i < 10; i++) begin
            logic       e;
            logic [2:0] got;
            e = ((i % 5) != 4);
            @(negedge clk);
            got = {b4.dma_grant, b4.cpu_pause, b4.dma_pause};
            checks++;
            if (got !== {e, e, ~e}) begin
                errors++;
                $display("FAIL run_limit c%0d: got %b want %b",
                         i, got, {e, e, ~e});
            end
            step();
        end
    endtask

    task automatic test_write_suppress;
        b4.dma_write = 1'b1;
        b4.cpu_write = 1'b1;
        b4.cpu_addr  = 32'h0300_0000;
        b4.bus_pause = 1'b1;
        @(negedge clk);
        checks++;
        if ({b4.dma_grant, b4.bus_write} !== 2'b11) begin
            errors++;
            $display("FAIL ws_wr_on: got %b want 11",
                     {b4.dma_grant, b4.bus_write});
        end
        step();
        b4.dma_req = 1'b0;
        #1;
        checks++;
        if ({b4.dma_grant, b4.bus_write} !== 2'b10) begin
            errors++;
            $display("FAIL ws_drop_now: got %b want 10",
                     {b4.dma_grant, b4.bus_write});
        end
        step();
        @(negedge clk);
        checks++;
        if ({b4.dma_grant, b4.bus_write, b4.dma_pause}
            !== 3'b101) begin
            errors++;
            $display("FAIL ws_hold: got %b want 101",
                     {b4.dma_grant, b4.bus_write, b4.dma_pause});
        end
        step();
        b4.bus_pause = 1'b0;
        @(negedge clk);
        checks++;
        if ({b4.dma_grant, b4.bus_write, b4.dma_pause}
            !== 3'b100) begin
            errors++;
            $display("FAIL ws_done: got %b want 100",
                     {b4.dma_grant, b4.bus_write, b4.dma_pause});
        end
        step();
        @(negedge clk);
        checks++;
        if ({b4.dma_grant, b4.bus_write, b4.cpu_pause}
            !== 3'b010) begin
            errors++;
            $display("FAIL ws_cpu_back: got %b want 010",
                     {b4.dma_grant, b4.bus_write, b4.cpu_pause});
        end
        checks++;
        if (b4.bus_addr !== 32'h0300_0000) begin
            errors++;
            $display("FAIL ws_cpu_addr: got %h want %h",
                     b4.bus_addr, 32'h0300_0000);
        end
        b4.cpu_write = 1'b0;
        b4.dma_write = 1'b0;
        step();
    endtask

    task automatic test_async_reset;
        b4.dma_req = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (b4.dma_grant !== 1'b1) begin
            errors++;
            $display("FAIL ar_pre_grant: got %b want 1",
                     b4.dma_grant);
        end
        #2;
        rst_b = 1'b0;
        #1;
        checks++;
        if ({b4.dma_grant, b4.cpu_dma_active, b4.dma_pause}
            !== 3'b001) begin
            errors++;
            $display("FAIL ar_outputs: got %b want 001",
                     {b4.dma_grant, b4.cpu_dma_active,
                      b4.dma_pause});
        end
        checks++;
        if (b4.bus_addr !== 32'h0300_0000) begin
            errors++;
            $display("FAIL ar_bus_addr: got %h want %h",
                     b4.bus_addr, 32'h0300_0000);
        end
        b4.dma_req = 1'b0;
        @(negedge clk);
        #1;
        rst_b = 1'b1;
        step();
    endtask

    task automatic test_unlimited;
        b0.dma_req   = 1'b1;
        b0.dma_addr  = 32'h0600_0000;
        b0.dma_wdata = 32'h1234_5678;
        b0.dma_size  = SIZE_HALF;
        b0.bus_pause = 1'b0;
        @(negedge clk);
        checks++;
        if (b0.dma_grant !== 1'b0) begin
            errors++;
            $display("FAIL ul_pre_grant: got %b want 0",
                     b0.dma_grant);
        end
        step();
        @(negedge clk);
        checks++;
        if ({b0.bus_wdata, b0.bus_size}
            !== {32'h1234_5678, SIZE_HALF}) begin
            errors++;
            $display("FAIL ul_mux: got %h/%h want %h/%h",
                     b0.bus_wdata, b0.bus_size,
                     32'h1234_5678, SIZE_HALF);
        end
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            checks++;
            if ({b0.dma_grant, b0.cpu_pause} !== 2'b11) begin
                errors++;
                $display("FAIL ul_run c%0d: got %b want 11",
                         i, {b0.dma_grant, b0.cpu_pause});
            end
            step();
        end
    endtask

    initial begin
        init_inputs();
        test_reset();
        test_cpu_read();
        test_run_limit();
        test_write_suppress();
        test_async_reset();
        test_unlimited();
        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
